// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    LD_BURST = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_burst_counter.sv
// Loader burst sequencer: latches base/length at grant, counts beats,
// and produces the wrapped beat address and the last-beat flag.
module mem_burst_counter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  beat;
  logic [LEN_W-1:0]  last_beat;

  // len-1 in LEN_W bits maps a zero length field onto 2^LEN_W beats for free
  always_ff @(posedge clk) begin
    if (rst) begin
      beat      <= '0;
      last_beat <= '0;
    end else if (load) begin
      beat      <= '0;
      last_beat <= len_in - LEN_W'(1);
    end else if (step) begin
      beat      <= beat + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load) base <= base_in;
  end

  assign addr = base + ADDR_W'(beat);
  assign last = (beat == last_beat);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data memory port between CPU single accesses and loader bursts.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is CPU priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [LEN_W-1:0]  ld_len,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state, state_nxt;
  logic              ld_live, done;
  logic              cpu_elig, ld_elig, cpu_win;
  logic              grant_cpu, grant_ld;
  logic [ADDR_W-1:0] burst_addr;
  logic              burst_last;

  assign ld_live = (state == LD_BURST) && ld_req;
  assign done    = (state == IDLE) || (state == CPU_ACC) ||
                   ((state == LD_BURST) && (!ld_req || burst_last));

  // A requester finishing at this edge still holds its request through the
  // ack cycle, so it is not eligible for an immediate re-grant.
  assign cpu_elig = cpu_req && (state != CPU_ACC);
  assign ld_elig  = ld_req && (state != LD_BURST);

`ifdef MEM_ARB_RR_EN
  req_id_t last_grant;

  assign cpu_win = cpu_elig && (!ld_elig || (last_grant == REQ_LD));

  always_ff @(posedge clk) begin
    if (rst)            last_grant <= REQ_CPU;
    else if (grant_cpu) last_grant <= REQ_CPU;
    else if (grant_ld)  last_grant <= REQ_LD;
  end
`else
  assign cpu_win = cpu_elig;
`endif

  assign grant_cpu = done && cpu_win;
  assign grant_ld  = done && ld_elig && !cpu_win;

  mem_burst_counter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_burst (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_ld),
    .step    (ld_live),
    .base_in (ld_addr),
    .len_in  (ld_len),
    .addr    (burst_addr),
    .last    (burst_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (done) begin
      if (grant_cpu)     state_nxt = CPU_ACC;
      else if (grant_ld) state_nxt = LD_BURST;
      else               state_nxt = IDLE;
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    ld_ack    = 1'b0;
    case (state)
      CPU_ACC: begin
        cpu_ack   = 1'b1;
        mem_write = cpu_we;
        mem_read  = !cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      LD_BURST: begin
        if (ld_req) begin
          ld_ack    = 1'b1;
          mem_write = ld_we;
          mem_read  = !ld_we;
          mem_addr  = burst_addr;
          mem_wdata = ld_wdata;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // Read data captured at the edge closing the access cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      ld_rvalid  <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
    end else begin
      cpu_rvalid <= (state == CPU_ACC) && !cpu_we;
      ld_rvalid  <= ld_live && !ld_we;
      if ((state == CPU_ACC) && !cpu_we) cpu_rdata <= mem_rdata;
      if (ld_live && !ld_we)             ld_rdata  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       ld_req, ld_we, ld_ack, ld_rvalid;
  logic [7:0] ld_addr, ld_wdata, ld_rdata;
  logic [3:0] ld_len;
  logic       mem_read, mem_write, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_len(ld_len), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Physical memory driven by the DUT strobes; writes commit at negedge
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  initial forever begin
    @(negedge clk);
    if (mem_write === 1'b1) mem[mem_addr] = mem_wdata;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: who owns the port, next loader address, beats left
  logic [7:0] ref_mem [256];
  int         m_owner = 0;
  int         m_addr = 0;
  int         m_left = 0;
  bit         m_ptr_ld = 1'b0;
  bit         m_cpu_rv = 1'b0, m_ld_rv = 1'b0;
  logic [7:0] m_cpu_rd = 8'h00, m_ld_rd = 8'h00;
  bit         cmp_on = 1'b0;

  function automatic logic [39:0] exp_out();
    logic ca, la, rd, wr;
    logic [7:0] a, w;
    ca = 1'b0; la = 1'b0; rd = 1'b0; wr = 1'b0; a = 8'h00; w = 8'h00;
    if (m_owner == 1) begin
      ca = 1'b1; wr = cpu_we; rd = !cpu_we; a = cpu_addr; w = cpu_wdata;
    end else if (m_owner == 2 && ld_req) begin
      la = 1'b1; wr = ld_we; rd = !ld_we; a = 8'(m_addr); w = ld_wdata;
    end
    return {ca, la, rd, wr, (m_owner != 0), m_cpu_rv, m_ld_rv, 1'b0, a, w, m_cpu_rd, m_ld_rd};
  endfunction

  logic [39:0] dut_pack;
  assign dut_pack = {cpu_ack, ld_ack, mem_read, mem_write, busy, cpu_rvalid, ld_rvalid, 1'b0,
                     mem_addr, mem_wdata, cpu_rdata, ld_rdata};

  initial forever begin
    logic [39:0] e;
    bit done, c, l;
    int win;
    @(posedge clk);
    e = exp_out();
    if (e[36]) ref_mem[e[31:24]] = e[23:16];
    if (rst) begin
      m_owner = 0; m_addr = 0; m_left = 0; m_ptr_ld = 1'b0;
      m_cpu_rv = 1'b0; m_ld_rv = 1'b0; m_cpu_rd = 8'h00; m_ld_rd = 8'h00;
    end else begin
      m_cpu_rv = (m_owner == 1) && !cpu_we;
      if (m_cpu_rv) m_cpu_rd = ref_mem[cpu_addr];
      m_ld_rv = (m_owner == 2) && ld_req && !ld_we;
      if (m_ld_rv) m_ld_rd = ref_mem[8'(m_addr)];
      done = (m_owner != 2) || !ld_req || (m_left == 1);
      if (!done) begin
        m_addr = (m_addr + 1) % 256;
        m_left--;
      end else begin
        c = cpu_req && (m_owner != 1);
        l = ld_req && (m_owner != 2);
        if (c && l) win = (RR && !m_ptr_ld) ? 2 : 1;
        else if (c) win = 1;
        else if (l) win = 2;
        else win = 0;
        if (win == 2) begin
          m_addr = int'(ld_addr);
          m_left = (ld_len == 4'd0) ? 16 : int'(ld_len);
          m_ptr_ld = 1'b1;
        end else if (win == 1) begin
          m_ptr_ld = 1'b0;
        end
        m_owner = win;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) check("cycle", 64'(dut_pack), 64'(exp_out()));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [7:0] addr, input logic [7:0] data,
                            input logic [7:0] exp_rd);
    tick();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    @(negedge clk);
    check("cpu ack before grant", cpu_ack, 0);
    @(negedge clk);
    check("cpu ack at k+1", cpu_ack, 1);
    check("cpu mem_addr", mem_addr, addr);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("cpu rvalid at k+2", cpu_rvalid, !we);
    if (!we) check("cpu rdata", cpu_rdata, exp_rd);
    @(negedge clk);
    check("cpu rvalid one cycle", cpu_rvalid, 0);
    @(posedge clk); #1;
  endtask

  // Runs loader beats with ld_req already high until n acks (bounded)
  task automatic ld_beats(input int n, input logic [7:0] step,
                          output int acks, output int rvs, output int busyc);
    bit a;
    acks = 0; rvs = 0; busyc = 0;
    for (int cyc = 0; cyc < 40 && acks < n; cyc++) begin
      @(negedge clk);
      busyc += int'(busy);
      rvs   += int'(ld_rvalid);
      a = ld_ack;
      if (a) acks++;
      @(posedge clk); #1;
      if (a) ld_wdata = ld_wdata + step;
    end
  endtask

  task automatic ld_burst(input logic we, input logic [7:0] addr, input logic [3:0] len,
                          input logic [7:0] d0, output int acks, output int rvs, output int busyc);
    tick();
    ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_len = len; ld_wdata = d0;
    ld_beats((len == 4'd0) ? 16 : int'(len), 8'h11, acks, rvs, busyc);
    ld_req = 1'b0;
    @(negedge clk);
    busyc += int'(busy);
    rvs   += int'(ld_rvalid);
  endtask

  initial begin
    int acks, rvs, busyc, bad;
    bit ca, la, c_act, l_act;
    int l_need, l_got;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_len = 4'd0; ld_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs", 64'(dut_pack), 0);
    tick();
    @(negedge clk);
    check("idle after release", busy, 0);

    // CPU write then read back
    cpu_access(1'b1, 8'h05, 8'hA5, 8'h00);
    check("mem[05] written", mem[8'h05], 8'hA5);
    cpu_access(1'b0, 8'h05, 8'h00, 8'hA5);

    // Loader write burst wrapping 0xFF -> 0x00
    ld_burst(1'b1, 8'hFE, 4'd4, 8'h11, acks, rvs, busyc);
    check("wrap acks", acks, 4);
    check("wrap busy cycles", busyc, 4);
    check("mem[FE]", mem[8'hFE], 8'h11);
    check("mem[FF]", mem[8'hFF], 8'h22);
    check("mem[00]", mem[8'h00], 8'h33);
    check("mem[01]", mem[8'h01], 8'h44);

    // ld_len = 0 read burst: 16 beats
    ld_burst(1'b0, 8'hF8, 4'd0, 8'h00, acks, rvs, busyc);
    check("len0 acks", acks, 16);
    check("len0 rvalids", rvs, 16);

    // Contention with loader last granted: CPU wins in both modes
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h3C;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_len = 4'd2; ld_wdata = 8'h51;
    @(negedge clk);
    @(negedge clk);
    check("tie1 cpu_ack", cpu_ack, 1);
    check("tie1 ld_ack", ld_ack, 0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("tie1 loader at k+2", ld_ack, 1);
    @(posedge clk); #1;
    ld_wdata = 8'h52;
    @(negedge clk);
    check("tie1 loader beat 1", ld_ack, 1);
    @(posedge clk); #1;
    ld_req = 1'b0;
    check("mem[21]", mem[8'h21], 8'h52);

    // Contention with CPU last granted: loader wins only under round-robin
    cpu_access(1'b1, 8'h11, 8'h77, 8'h00);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h12; cpu_wdata = 8'h88;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h30; ld_len = 4'd1; ld_wdata = 8'h99;
    @(negedge clk);
    @(negedge clk);
    check("tie2 cpu_ack", cpu_ack, RR ? 1'b0 : 1'b1);
    check("tie2 ld_ack", ld_ack, RR ? 1'b1 : 1'b0);
    @(posedge clk); #1;
    if (RR) ld_req = 1'b0;
    else cpu_req = 1'b0;
    @(negedge clk);
    check("tie2 loser served next", RR ? cpu_ack : ld_ack, 1);
    @(posedge clk); #1;
    cpu_req = 1'b0; ld_req = 1'b0;

    // Abort at beat 2 of 8 with a CPU request granted at the same edge
    tick();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h40; ld_len = 4'd8; ld_wdata = 8'hC0;
    ld_beats(2, 8'h01, acks, rvs, busyc);
    check("abort acks before drop", acks, 2);
    ld_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'hEE;
    @(negedge clk);
    check("abort no ld_ack", ld_ack, 0);
    check("abort no write", mem_write, 0);
    @(negedge clk);
    check("cpu after abort", cpu_ack, 1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    check("abort mem[41]", mem[8'h41], 8'hC1);
    check("abort mem[42]", mem[8'h42], 8'h00);

    // Reset in the middle of an 8-beat burst
    tick();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h80; ld_len = 4'd8; ld_wdata = 8'hB0;
    ld_beats(2, 8'h01, acks, rvs, busyc);
    rst = 1'b1;
    @(negedge clk);
    check("beat 2 before reset", ld_ack, 1);
    @(posedge clk); #1;
    ld_req = 1'b0;
    @(negedge clk);
    check("outputs in reset", 64'(dut_pack), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle after mid-burst reset", 64'(dut_pack), 0);
    check("rst mem[82]", mem[8'h82], 8'hB2);
    check("rst mem[83]", mem[8'h83], 8'h00);

    // Randomized traffic from both requesters
    c_act = 1'b0; l_act = 1'b0; l_need = 0; l_got = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ca = cpu_ack;
      la = ld_ack;
      @(posedge clk); #1;
      if (c_act && ca) begin
        cpu_req = 1'b0; c_act = 1'b0;
      end else if (!c_act && $urandom_range(0, 3) == 0) begin
        c_act = 1'b1; cpu_req = 1'b1; cpu_we = 1'($urandom);
        cpu_addr = 8'($urandom_range(0, 47) + 240); cpu_wdata = 8'($urandom);
      end
      if (l_act) begin
        if (la) begin
          l_got++;
          ld_wdata = 8'($urandom);
        end
        if (l_got == l_need || $urandom_range(0, 39) == 0) begin
          ld_req = 1'b0; l_act = 1'b0;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        l_act = 1'b1; ld_req = 1'b1; ld_we = 1'($urandom);
        ld_addr = 8'($urandom_range(0, 47) + 240); ld_len = 4'($urandom);
        ld_wdata = 8'($urandom);
        l_need = (ld_len == 4'd0) ? 16 : int'(ld_len);
        l_got = 0;
      end
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("memory image", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
